// File: rtl/prio_irq_encoder_if.sv
// Request/grant bundle for prio_irq_encoder: active-low requests, mask and ack in,
// registered active-low code, grant-valid and cascade enable-out back.
interface prio_irq_encoder_if #(
    parameter int N = 8
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic         en_n;
    logic [N-1:0] req_n;
    logic [N-1:0] mask;
    logic         ack;
    logic [W-1:0] code_n;
    logic         gs_n;
    logic         eo_n;

    modport master (
        output en_n, req_n, mask, ack,
        input  code_n, gs_n, eo_n
    );

    modport slave (
        input  en_n, req_n, mask, ack,
        output code_n, gs_n, eo_n
    );
endinterface

// File: rtl/prio_irq_encoder.sv
// Edge-capturing interrupt priority encoder with ack handshake and cascade enable-out.
// Define PRIO_ROTATE_EN for round-robin priority; fixed highest-index priority otherwise.
module prio_irq_encoder #(
    parameter int N = 8
) (
    input logic              clk,
    input logic              rst,
    prio_irq_encoder_if.slave bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e       state_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] prev_q;
    logic [W-1:0] code_n_q;
    logic         gs_n_q;
    logic         eo_n_q;
`ifdef PRIO_ROTATE_EN
    logic [W-1:0] last_q;
    logic         found;
`endif

    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] avail;
    logic [W-1:0] win;
    logic         any;

    always_comb begin
        set   = ~bus.req_n & prev_q & ~bus.mask;
        avail = pending_q & ~bus.mask;
        any   = |avail;
        win   = '0;
        clr   = '0;
        // The granted index is recoverable from the registered code.
        if (state_q == StHold && bus.ack && !bus.en_n) begin
            clr = {{(N-1){1'b0}}, 1'b1} << (~code_n_q);
        end
`ifdef PRIO_ROTATE_EN
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && avail[(int'(last_q) + 2 * N - 1 - k) % N]) begin
                win   = W'((int'(last_q) + 2 * N - 1 - k) % N);
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (avail[i]) win = W'(i);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            prev_q    <= '1;
            code_n_q  <= '1;
            gs_n_q    <= 1'b1;
            eo_n_q    <= 1'b1;
`ifdef PRIO_ROTATE_EN
            last_q    <= '0;
`endif
        end else begin
            prev_q    <= bus.req_n;
            // A bit both cleared by ack and re-captured this cycle stays set.
            pending_q <= (pending_q & ~clr) | set;
            unique case (state_q)
                StIdle: begin
                    if (!bus.en_n && any) begin
                        code_n_q <= ~win;
                        gs_n_q   <= 1'b0;
                        eo_n_q   <= 1'b1;
                        state_q  <= StHold;
                    end else begin
                        code_n_q <= '1;
                        gs_n_q   <= 1'b1;
                        eo_n_q   <= bus.en_n | any;
                    end
                end
                StHold: begin
                    if (bus.en_n) begin
                        code_n_q <= '1;
                        gs_n_q   <= 1'b1;
                        eo_n_q   <= 1'b1;
                        state_q  <= StIdle;
                    end else if (bus.ack) begin
                        code_n_q <= '1;
                        gs_n_q   <= 1'b1;
                        eo_n_q   <= 1'b1;
                        state_q  <= StIdle;
`ifdef PRIO_ROTATE_EN
                        last_q   <= ~code_n_q;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.code_n = code_n_q;
    assign bus.gs_n   = gs_n_q;
    assign bus.eo_n   = eo_n_q;
endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed self-checking bench for prio_irq_encoder with N=8; expected values are
// hand-derived per scenario (rotation expectations follow PRIO_ROTATE_EN).
module tb_prio_irq_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    prio_irq_encoder_if #(.N(8)) bus ();

    prio_irq_encoder #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] code);
        check({tag, "_code"}, {29'd0, bus.code_n}, {29'd0, code});
        check({tag, "_gs"}, {31'd0, bus.gs_n}, 32'd0);
        check({tag, "_eo"}, {31'd0, bus.eo_n}, 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic eo);
        check({tag, "_code"}, {29'd0, bus.code_n}, 32'd7);
        check({tag, "_gs"}, {31'd0, bus.gs_n}, 32'd1);
        check({tag, "_eo"}, {31'd0, bus.eo_n}, {31'd0, eo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_exp [4];
        bus.en_n  = 1'b0;
        bus.req_n = 8'hFF;
        bus.mask  = 8'h00;
        bus.ack   = 1'b0;
        tick();
        tick();
        check_idle("reset", 1'b1);
        rst = 1'b0;
        tick();
        check_idle("idle_empty", 1'b0);

        // Single request on bit 7
        bus.req_n = 8'h7F;
        tick();
        check("lat_k_gs", {31'd0, bus.gs_n}, 32'd1);
        tick();
        check_grant("g7", 3'b000);
        bus.ack = 1'b1;
        tick();
        check_idle("g7_ack", 1'b1);
        bus.ack = 1'b0;
        tick();
        check_idle("g7_done", 1'b0);
        tick();
        check_idle("held_low_once", 1'b0);

        // Bits 7, 5, 0 together
        bus.req_n = 8'hFF;
        tick();
        bus.req_n = 8'h5E;
        tick();
        tick();
        check_grant("m7", 3'b000);
        bus.ack = 1'b1;
        tick();
        check("m7_ack_gs", {31'd0, bus.gs_n}, 32'd1);
        bus.ack = 1'b0;
        tick();
        check_grant("m5", 3'b010);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        check_grant("m0", 3'b111);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        check_idle("m_done", 1'b0);

        // Grant 6 must stay stable under mask and request changes
        bus.req_n = 8'hFF;
        tick();
        bus.req_n = 8'hBF;
        tick();
        tick();
        check_grant("h6", 3'b001);
        bus.mask  = 8'hFF;
        bus.req_n = 8'hFF;
        tick();
        check_grant("h6_mask", 3'b001);
        bus.req_n = 8'hBF;
        tick();
        check_grant("h6_toggle", 3'b001);
        bus.ack = 1'b1;
        tick();
        bus.ack  = 1'b0;
        bus.mask = 8'h00;
        tick();
        check_idle("h6_done", 1'b0);

        // Disable during hold, then re-enable
        bus.req_n = 8'hFF;
        tick();
        bus.req_n = 8'hEF;
        tick();
        tick();
        check_grant("e4", 3'b011);
        bus.en_n = 1'b1;
        tick();
        check_idle("e4_dis", 1'b1);
        bus.en_n = 1'b0;
        tick();
        check_grant("e4_reissue", 3'b011);

        // Ack and re-capture of the same bit in one cycle: capture wins
        bus.req_n = 8'hFF;
        tick();
        bus.req_n = 8'hEF;
        bus.ack   = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        check_grant("setwin", 3'b011);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        check_idle("setwin_done", 1'b0);

        // Pending bit retained while masked
        bus.req_n = 8'hFF;
        tick();
        bus.req_n = 8'hF7;
        tick();
        bus.mask = 8'h08;
        tick();
        check_idle("masked_pend", 1'b0);
        bus.mask = 8'h00;
        tick();
        check_grant("unmask3", 3'b100);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;

        // Asynchronous reset during hold
        bus.req_n = 8'hFF;
        tick();
        bus.req_n = 8'hDF;
        tick();
        tick();
        check_grant("r5", 3'b010);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_gs", {31'd0, bus.gs_n}, 32'd1);
        check("rst_async_code", {29'd0, bus.code_n}, 32'd7);
        bus.req_n = 8'hFF;
        tick();
        rst = 1'b0;
        tick();
        check_idle("rst_cleared", 1'b0);

        // Bits 7 and 2 re-raised at every ack
`ifdef PRIO_ROTATE_EN
        rr_exp = '{3'd7, 3'd2, 3'd7, 3'd2};
`else
        rr_exp = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
        bus.req_n = 8'h7B;
        tick();
        tick();
        check_grant("rr0", ~rr_exp[0]);
        for (int i = 1; i < 4; i++) begin
            bus.req_n = 8'hFF;
            tick();
            bus.req_n = 8'h7B;
            bus.ack   = 1'b1;
            tick();
            bus.ack = 1'b0;
            tick();
            check_grant($sformatf("rr%0d", i), ~rr_exp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
